// File: rtl/selection_of_avatar_param.sv
// ---------------------------------------------------------------------------
// selection_of_avatar_param
//
// Purpose: a three-phase election engine. A phase timer walks the design
// through REG (registration), VOTE and RESULT. Voters are addressed by a
// flat id whose top BOX_W bits name their ballot box. During REG voters
// register. During VOTE registered voters cast one vote each. The first
// RESULT cycle publishes the winner, which then holds until RESET.
//
// Optional feature: define VOTE_REVOKE_EN to allow a voter to revoke a
// vote during VOTE (mode 10). Each voter's chosen candidate is then
// stored so the right tally can be decremented. Without the macro,
// mode 10 during VOTE does nothing and NotVoted stays 0.
//
// Handshake: an operation is taken when req=1 at a rising edge of CLK.
// It is evaluated against the phase that held before that edge. Its
// status flags are pulsed high for exactly one cycle after the edge.
// mode=11 is a no-op: it raises no flags and changes no state.
//
// Ports:
//   CLK, RESET                synchronous active-high reset
//   req, mode[1:0]            op valid; 00 register, 01 vote, 10 revoke, 11 nop
//   userID[BOX_W+IDX_W-1:0]   voter id (MSBs = ballot box)
//   candidate[CAND_W-1:0]     chosen candidate for a vote
//   ballotBoxId               box of the most recent accepted op
//   numberOfRegisteredVoters  registered voter count
//   numberOfVotesWinner       winning tally (valid with ResultValid)
//   WinnerId, Tie, ResultValid  election outcome
//   phase[1:0]                00 REG, 01 VOTE, 10 RESULT (FSM state)
//   AlreadyRegistered, AlreadyVoted, NotRegistered, VotingHasNotStarted,
//   RegistrationHasEnded, NotVoted, VotingHasEnded   one-cycle status pulses
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module selection_of_avatar_param #(
    parameter int BOX_W       = 2,
    parameter int IDX_W       = 4,
    parameter int CAND_W      = 2,
    parameter int REG_CYCLES  = 100,
    parameter int VOTE_CYCLES = 100
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     req,
    input  logic [1:0]               mode,
    input  logic [BOX_W+IDX_W-1:0]   userID,
    input  logic [CAND_W-1:0]        candidate,
    output logic [BOX_W-1:0]         ballotBoxId,
    output logic [BOX_W+IDX_W:0]     numberOfRegisteredVoters,
    output logic [BOX_W+IDX_W:0]     numberOfVotesWinner,
    output logic [CAND_W-1:0]        WinnerId,
    output logic                     Tie,
    output logic                     ResultValid,
    output logic [1:0]               phase,
    output logic                     AlreadyRegistered,
    output logic                     AlreadyVoted,
    output logic                     NotRegistered,
    output logic                     VotingHasNotStarted,
    output logic                     RegistrationHasEnded,
    output logic                     NotVoted,
    output logic                     VotingHasEnded
);

    localparam int ID_W    = BOX_W + IDX_W;
    localparam int CNT_W   = ID_W + 1;
    localparam int NV      = 1 << ID_W;
    localparam int NC      = 1 << CAND_W;
    localparam int TMR_MAX = (REG_CYCLES > VOTE_CYCLES) ? REG_CYCLES : VOTE_CYCLES;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [TMR_W-1:0] TMR_ONE = TMR_W'(1);

    localparam logic [1:0] OP_REG    = 2'b00;
    localparam logic [1:0] OP_VOTE   = 2'b01;
    localparam logic [1:0] OP_REVOKE = 2'b10;
    localparam logic [1:0] OP_NOP    = 2'b11;

    // Bit positions of the status flags inside flags_d / flags_q
    localparam int F_AR   = 6;
    localparam int F_AV   = 5;
    localparam int F_NR   = 4;
    localparam int F_VHNS = 3;
    localparam int F_RHE  = 2;
    localparam int F_NV   = 1;
    localparam int F_VHE  = 0;

    typedef enum logic [1:0] {
        PH_REG    = 2'b00,
        PH_VOTE   = 2'b01,
        PH_RESULT = 2'b10
    } phase_t;

    phase_t           phase_q, phase_d;
    logic [TMR_W-1:0] timer_q, timer_d;

    logic [NV-1:0]    registered_q;
    logic [NV-1:0]    voted_q;
    logic [CNT_W-1:0] tally_q [NC];
    logic [CNT_W-1:0] tally_d [NC];
`ifdef VOTE_REVOKE_EN
    logic [CAND_W-1:0] choice_q [NV];
    logic              vote_clr;
`endif

    logic             accept;
    logic             is_reg;
    logic             is_voted;
    logic             reg_set;
    logic             vote_set;
    logic [6:0]       flags_d;
    logic [6:0]       flags_q;

    logic [CNT_W-1:0]  best_cnt;
    logic [CAND_W-1:0] best_id;
    logic              tie_d;

    // ---------------- phase FSM: next state ----------------
    // The timer restarts at each phase boundary and freezes in RESULT.
    // Freezing it there keeps the terminal phase from wrapping back.
    always_comb begin
        phase_d = phase_q;
        timer_d = timer_q + TMR_ONE;
        case (phase_q)
            PH_REG: begin
                if (timer_q == TMR_W'(REG_CYCLES - 1)) begin
                    phase_d = PH_VOTE;
                    timer_d = '0;
                end
            end
            PH_VOTE: begin
                if (timer_q == TMR_W'(VOTE_CYCLES - 1)) begin
                    phase_d = PH_RESULT;
                    timer_d = '0;
                end
            end
            default: timer_d = timer_q;
        endcase
    end

    // ---------------- operation decode ----------------
    always_comb begin
        accept   = req && (mode != OP_NOP);
        is_reg   = registered_q[userID];
        is_voted = voted_q[userID];
        reg_set  = 1'b0;
        vote_set = 1'b0;
        flags_d  = '0;
`ifdef VOTE_REVOKE_EN
        vote_clr = 1'b0;
`endif
        if (accept) begin
            case (phase_q)
                PH_REG: begin
                    if (mode == OP_REG) begin
                        if (is_reg) flags_d[F_AR] = 1'b1;
                        else        reg_set       = 1'b1;
                    end else begin
                        flags_d[F_VHNS] = 1'b1;
                    end
                end
                PH_VOTE: begin
                    case (mode)
                        OP_REG:  flags_d[F_RHE] = 1'b1;
                        OP_VOTE: begin
                            if (!is_reg)       flags_d[F_NR] = 1'b1;
                            else if (is_voted) flags_d[F_AV] = 1'b1;
                            else               vote_set      = 1'b1;
                        end
                        OP_REVOKE: begin
`ifdef VOTE_REVOKE_EN
                            if (!is_reg)        flags_d[F_NR] = 1'b1;
                            else if (!is_voted) flags_d[F_NV] = 1'b1;
                            else                vote_clr      = 1'b1;
`endif
                        end
                        default: ;
                    endcase
                end
                default: flags_d[F_VHE] = 1'b1;
            endcase
        end
    end

    // ---------------- tally update ----------------
    always_comb begin
        for (int i = 0; i < NC; i++) tally_d[i] = tally_q[i];
        if (vote_set) tally_d[candidate] = tally_q[candidate] + CNT_ONE;
`ifdef VOTE_REVOKE_EN
        // A voted voter's stored choice always has a non-zero tally.
        if (vote_clr) tally_d[choice_q[userID]] = tally_q[choice_q[userID]] - CNT_ONE;
`endif
    end

    // ---------------- winner search ----------------
    // This uses the post-update tallies, so a vote taken on the last VOTE
    // edge counts in the result latched on that same edge.
    always_comb begin
        best_cnt = tally_d[0];
        best_id  = '0;
        tie_d    = 1'b0;
        for (int i = 1; i < NC; i++) begin
            if (tally_d[i] > best_cnt) begin
                best_cnt = tally_d[i];
                best_id  = CAND_W'(i);
            end
        end
        for (int i = 0; i < NC; i++) begin
            if ((tally_d[i] == best_cnt) && (CAND_W'(i) != best_id)) tie_d = 1'b1;
        end
    end

    // ---------------- state and output registers ----------------
    always_ff @(posedge CLK) begin
        if (RESET) begin
            phase_q                  <= PH_REG;
            timer_q                  <= '0;
            registered_q             <= '0;
            voted_q                  <= '0;
            flags_q                  <= '0;
            ballotBoxId              <= '0;
            numberOfRegisteredVoters <= '0;
            numberOfVotesWinner      <= '0;
            WinnerId                 <= '0;
            Tie                      <= 1'b0;
            ResultValid              <= 1'b0;
            for (int i = 0; i < NC; i++) tally_q[i] <= '0;
`ifdef VOTE_REVOKE_EN
            for (int i = 0; i < NV; i++) choice_q[i] <= '0;
`endif
        end else begin
            phase_q <= phase_d;
            timer_q <= timer_d;
            flags_q <= flags_d;
            for (int i = 0; i < NC; i++) tally_q[i] <= tally_d[i];
            if (accept) ballotBoxId <= userID[ID_W-1 -: BOX_W];
            if (reg_set) begin
                registered_q[userID]     <= 1'b1;
                numberOfRegisteredVoters <= numberOfRegisteredVoters + CNT_ONE;
            end
            if (vote_set) begin
                voted_q[userID] <= 1'b1;
`ifdef VOTE_REVOKE_EN
                choice_q[userID] <= candidate;
`endif
            end
`ifdef VOTE_REVOKE_EN
            if (vote_clr) voted_q[userID] <= 1'b0;
`endif
            if ((phase_q != PH_RESULT) && (phase_d == PH_RESULT)) begin
                WinnerId            <= best_id;
                numberOfVotesWinner <= best_cnt;
                Tie                 <= tie_d;
                ResultValid         <= 1'b1;
            end
        end
    end

    assign phase                = phase_q;
    assign AlreadyRegistered    = flags_q[F_AR];
    assign AlreadyVoted         = flags_q[F_AV];
    assign NotRegistered        = flags_q[F_NR];
    assign VotingHasNotStarted  = flags_q[F_VHNS];
    assign RegistrationHasEnded = flags_q[F_RHE];
    assign NotVoted             = flags_q[F_NV];
    assign VotingHasEnded       = flags_q[F_VHE];

endmodule

// File: tb/tb_selection_of_avatar_param.sv
// ---------------------------------------------------------------------------
// tb_selection_of_avatar_param
//
// Purpose: self-checking bench for selection_of_avatar_param. The reference
// model tracks elapsed cycles, per-voter registration, vote state and
// choice. It derives the phase from the cycle count and finds the winner
// by counting ballots. Directed episodes reproduce the scenarios from the
// requirements. Randomized episodes follow them, one with a reset in the
// middle of VOTE. Define VOTE_REVOKE_EN for both bench and RTL to cover
// revocation.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_selection_of_avatar_param;

    localparam int BOX_W       = 2;
    localparam int IDX_W       = 4;
    localparam int CAND_W      = 2;
    localparam int REG_CYCLES  = 100;
    localparam int VOTE_CYCLES = 100;
    localparam int ID_W        = BOX_W + IDX_W;
    localparam int CNT_W       = ID_W + 1;
    localparam int NV          = 1 << ID_W;
    localparam int NC          = 1 << CAND_W;
    localparam int END_CYC     = REG_CYCLES + VOTE_CYCLES;

    localparam int F_AR = 6, F_AV = 5, F_NR = 4, F_VHNS = 3, F_RHE = 2, F_NV = 1, F_VHE = 0;

    // ---------------- clock / reset ----------------
    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic              RESET;
    logic              req;
    logic [1:0]        mode;
    logic [ID_W-1:0]   userID;
    logic [CAND_W-1:0] candidate;
    logic [BOX_W-1:0]  ballotBoxId;
    logic [CNT_W-1:0]  numberOfRegisteredVoters;
    logic [CNT_W-1:0]  numberOfVotesWinner;
    logic [CAND_W-1:0] WinnerId;
    logic              Tie, ResultValid;
    logic [1:0]        phase;
    logic AlreadyRegistered, AlreadyVoted, NotRegistered, VotingHasNotStarted;
    logic RegistrationHasEnded, NotVoted, VotingHasEnded;
    logic [6:0]        got_flags;

    assign got_flags = {AlreadyRegistered, AlreadyVoted, NotRegistered, VotingHasNotStarted,
                        RegistrationHasEnded, NotVoted, VotingHasEnded};

    selection_of_avatar_param #(
        .BOX_W(BOX_W), .IDX_W(IDX_W), .CAND_W(CAND_W),
        .REG_CYCLES(REG_CYCLES), .VOTE_CYCLES(VOTE_CYCLES)
    ) dut (
        .CLK(CLK), .RESET(RESET), .req(req), .mode(mode), .userID(userID),
        .candidate(candidate), .ballotBoxId(ballotBoxId),
        .numberOfRegisteredVoters(numberOfRegisteredVoters),
        .numberOfVotesWinner(numberOfVotesWinner), .WinnerId(WinnerId), .Tie(Tie),
        .ResultValid(ResultValid), .phase(phase),
        .AlreadyRegistered(AlreadyRegistered), .AlreadyVoted(AlreadyVoted),
        .NotRegistered(NotRegistered), .VotingHasNotStarted(VotingHasNotStarted),
        .RegistrationHasEnded(RegistrationHasEnded), .NotVoted(NotVoted),
        .VotingHasEnded(VotingHasEnded)
    );

    // ---------------- checking ----------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int         m_cyc;
    bit         m_reg   [NV];
    bit         m_voted [NV];
    int         m_choice[NV];
    int         e_box, e_win, e_votes, e_tie, e_valid;
    logic [6:0] e_flags;

    function automatic int ph_of(input int c);
        if (c < REG_CYCLES) return 0;
        if (c < END_CYC)    return 1;
        return 2;
    endfunction

    function automatic int count_reg();
        int n = 0;
        for (int v = 0; v < NV; v++) n += int'(m_reg[v]);
        return n;
    endfunction

    task automatic model_result();
        int t[NC];
        int mx, nmax;
        for (int c = 0; c < NC; c++) t[c] = 0;
        for (int v = 0; v < NV; v++) if (m_voted[v]) t[m_choice[v]]++;
        mx = 0;
        for (int c = 0; c < NC; c++) if (t[c] > mx) mx = t[c];
        nmax  = 0;
        e_win = 0;
        for (int c = NC - 1; c >= 0; c--) if (t[c] == mx) begin e_win = c; nmax++; end
        e_votes = mx;
        e_tie   = (nmax >= 2) ? 1 : 0;
        e_valid = 1;
    endtask

    task automatic model(input bit rst, input bit r, input int m, input int id, input int c);
        int ph;
        if (rst) begin
            m_cyc = 0;
            for (int v = 0; v < NV; v++) begin m_reg[v] = 0; m_voted[v] = 0; m_choice[v] = 0; end
            e_box = 0; e_win = 0; e_votes = 0; e_tie = 0; e_valid = 0; e_flags = '0;
        end else begin
            ph      = ph_of(m_cyc);
            e_flags = '0;
            if (r && m != 3) begin
                e_box = id >> IDX_W;
                if (ph == 0) begin
                    if (m == 0) begin
                        if (m_reg[id]) e_flags[F_AR] = 1'b1;
                        else           m_reg[id]     = 1;
                    end else e_flags[F_VHNS] = 1'b1;
                end else if (ph == 1) begin
                    if (m == 0) e_flags[F_RHE] = 1'b1;
                    else if (m == 1) begin
                        if (!m_reg[id])     e_flags[F_NR] = 1'b1;
                        else if (m_voted[id]) e_flags[F_AV] = 1'b1;
                        else begin m_voted[id] = 1; m_choice[id] = c; end
                    end else begin
`ifdef VOTE_REVOKE_EN
                        if (!m_reg[id])        e_flags[F_NR] = 1'b1;
                        else if (!m_voted[id]) e_flags[F_NV] = 1'b1;
                        else                   m_voted[id]   = 0;
`endif
                    end
                end else e_flags[F_VHE] = 1'b1;
            end
            m_cyc++;
            if (ph_of(m_cyc) == 2 && e_valid == 0) model_result();
        end
    endtask

    task automatic check_all();
        check("phase", 32'(phase), ph_of(m_cyc));
        check("box", 32'(ballotBoxId), e_box);
        check("nreg", 32'(numberOfRegisteredVoters), count_reg());
        check("flags", 32'(got_flags), 32'(e_flags));
        check("winner", 32'(WinnerId), e_win);
        check("votes", 32'(numberOfVotesWinner), e_votes);
        check("tie", 32'(Tie), e_tie);
        check("valid", 32'(ResultValid), e_valid);
    endtask

    // ---------------- driver ----------------
    task automatic step(input bit rst, input bit r, input int m, input int id, input int c);
        @(negedge CLK);
        RESET     = rst;
        req       = r;
        mode      = 2'(m);
        userID    = ID_W'(id);
        candidate = CAND_W'(c);
        @(posedge CLK);
        model(rst, r, m, id, c);
        #1;
        check_all();
    endtask

    task automatic idle_to(input int target);
        while (m_cyc < target) step(0, 0, 0, 0, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int rst_at;
        RESET = 1'b1; req = 1'b0; mode = '0; userID = '0; candidate = '0;

        // Reset state
        step(1, 0, 0, 0, 0);
        check("rst_phase", 32'(phase), 0);
        check("rst_nreg", 32'(numberOfRegisteredVoters), 0);

        // Double registration of one voter
        step(0, 1, 0, 'h05, 0);
        check("r20_cnt1", 32'(numberOfRegisteredVoters), 1);
        step(0, 1, 0, 'h05, 0);
        check("r20_ar", 32'(AlreadyRegistered), 1);
        check("r20_cnt2", 32'(numberOfRegisteredVoters), 1);

        // Voting too early, and the REG/VOTE boundary
        step(0, 1, 1, 'h05, 1);
        check("r21_vhns", 32'(VotingHasNotStarted), 1);
        idle_to(REG_CYCLES - 1);
        step(0, 1, 0, 'h06, 0);
        check("r21_last_reg", 32'(numberOfRegisteredVoters), 2);
        check("r21_phase_vote", 32'(phase), 1);
        step(0, 1, 0, 'h07, 0);
        check("r21_rhe", 32'(RegistrationHasEnded), 1);
        check("r21_cnt", 32'(numberOfRegisteredVoters), 2);

        // Clear winner, repeat voter, unknown voter
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 'h01, 0);
        step(0, 1, 0, 'h11, 0);
        step(0, 1, 0, 'h21, 0);
        check("r22_box", 32'(ballotBoxId), 2);
        idle_to(REG_CYCLES);
        step(0, 1, 1, 'h01, 2);
        step(0, 1, 1, 'h11, 2);
        step(0, 1, 1, 'h21, 1);
        step(0, 1, 1, 'h01, 0);
        check("r22_av", 32'(AlreadyVoted), 1);
        step(0, 1, 1, 'h3F, 0);
        check("r22_nr", 32'(NotRegistered), 1);
        check("r22_pre_valid", 32'(ResultValid), 0);
        idle_to(END_CYC);
        check("r22_win", 32'(WinnerId), 2);
        check("r22_votes", 32'(numberOfVotesWinner), 2);
        check("r22_tie", 32'(Tie), 0);
        check("r22_valid", 32'(ResultValid), 1);
        step(0, 1, 0, 'h01, 0);
        check("r14_vhe", 32'(VotingHasEnded), 1);

        // Two-way tie, lowest index wins
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 'h02, 0);
        step(0, 1, 0, 'h13, 0);
        idle_to(REG_CYCLES);
        step(0, 1, 1, 'h02, 3);
        step(0, 1, 1, 'h13, 1);
        idle_to(END_CYC);
        check("r23_win", 32'(WinnerId), 1);
        check("r23_votes", 32'(numberOfVotesWinner), 1);
        check("r23_tie", 32'(Tie), 1);

        // No votes at all
        step(1, 0, 0, 0, 0);
        idle_to(END_CYC);
        check("r23z_win", 32'(WinnerId), 0);
        check("r23z_votes", 32'(numberOfVotesWinner), 0);
        check("r23z_tie", 32'(Tie), 1);
        check("r23z_valid", 32'(ResultValid), 1);

`ifdef VOTE_REVOKE_EN
        // Revoke and re-vote
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 'h01, 0);
        step(0, 1, 0, 'h02, 0);
        idle_to(REG_CYCLES);
        step(0, 1, 1, 'h01, 2);
        step(0, 1, 2, 'h01, 0);
        step(0, 1, 1, 'h01, 0);
        check("r24_revote", 32'(got_flags), 0);
        step(0, 1, 2, 'h02, 0);
        check("r24_nv", 32'(NotVoted), 1);
        idle_to(END_CYC);
        check("r24_win", 32'(WinnerId), 0);
        check("r24_votes", 32'(numberOfVotesWinner), 1);
`endif

        // Reset in the middle of VOTE, coincident with a request
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 'h05, 0);
        idle_to(REG_CYCLES);
        step(0, 1, 1, 'h05, 1);
        step(1, 1, 0, 'h05, 0);
        check("r25_phase", 32'(phase), 0);
        check("r25_cnt", 32'(numberOfRegisteredVoters), 0);
        check("r25_flags", 32'(got_flags), 0);
        step(0, 1, 0, 'h05, 0);
        check("r25_rereg_ar", 32'(AlreadyRegistered), 0);
        check("r25_rereg_cnt", 32'(numberOfRegisteredVoters), 1);
        idle_to(REG_CYCLES);
        step(0, 1, 1, 'h05, 3);
        check("r25_revote_av", 32'(AlreadyVoted), 0);
        idle_to(END_CYC);
        check("r25_win", 32'(WinnerId), 3);

        // Randomized episodes
        for (int ep = 0; ep < 4; ep++) begin
            rst_at = (ep == 3) ? int'($urandom_range(REG_CYCLES + 1, END_CYC - 2)) : -1;
            step(1, 0, 0, 0, 0);
            for (int k = 0; k < END_CYC + 20; k++) begin
                bit r;
                int m, id, c;
                r  = ($urandom_range(0, 9) < 7);
                m  = int'($urandom_range(0, 3));
                id = int'(($urandom_range(0, 3) << IDX_W) | $urandom_range(0, 3));
                c  = int'($urandom_range(0, NC - 1));
                step((k == rst_at) ? 1'b1 : 1'b0, r, m, id, c);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
